// File: rtl/challenge_initiator_pkg.sv
// Shared protocol constants, error codes and FSM states for the CHALLENGE initiator.
package challenge_initiator_pkg;

   localparam int FIELD_W = 8;

   localparam logic [FIELD_W-1:0] PROTOCOL_VERSION   = 8'h01;
   localparam logic [FIELD_W-1:0] MSG_CHALLENGE      = 8'h83;
   localparam logic [FIELD_W-1:0] MSG_CHALLENGE_AUTH = 8'h03;
   localparam logic [FIELD_W-1:0] MSG_ERROR          = 8'h7F;

   localparam logic [2:0] ERR_NONE          = 3'd0;
   localparam logic [2:0] ERR_TIMEOUT       = 3'd1;
   localparam logic [2:0] ERR_BAD_VERSION   = 3'd2;
   localparam logic [2:0] ERR_BAD_TYPE      = 3'd3;
   localparam logic [2:0] ERR_SLOT_MISMATCH = 3'd4;
   localparam logic [2:0] ERR_ERROR_MSG     = 3'd5;
   localparam logic [2:0] ERR_BAD_SLOT      = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEND      = 3'd1,
      ST_WAIT_RESP = 3'd2,
      ST_CHECK     = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   function automatic logic [31:0] challenge_header(input logic [FIELD_W-1:0] slot);
      return {PROTOCOL_VERSION, MSG_CHALLENGE, slot, 8'h00};
   endfunction

endpackage

// File: rtl/challenge_initiator_resp_checker.sv
// Combinational CHALLENGE_AUTH header validation; first failing rule sets the error code.
module challenge_initiator_resp_checker
   import challenge_initiator_pkg::*;
(
   input  logic [FIELD_W-1:0] version,
   input  logic [FIELD_W-1:0] msg_type,
   input  logic [FIELD_W-1:0] param1,
   input  logic [FIELD_W-1:0] exp_slot,
   output logic               pass,
   output logic [2:0]         err_code,
   output logic [FIELD_W-1:0] err_info
);

   always_comb begin
      pass     = 1'b0;
      err_code = ERR_NONE;
      err_info = '0;
      if (version != PROTOCOL_VERSION) begin
         err_code = ERR_BAD_VERSION;
      end else if (msg_type == MSG_ERROR) begin
         err_code = ERR_ERROR_MSG;
         err_info = param1;
      end else if (msg_type != MSG_CHALLENGE_AUTH) begin
         err_code = ERR_BAD_TYPE;
      end else if (param1 != exp_slot) begin
         err_code = ERR_SLOT_MISMATCH;
      end else begin
         pass = 1'b1;
      end
   end

endmodule

// File: rtl/challenge_initiator.sv
// CHALLENGE initiator: start->req_valid 1 cycle, resp_valid->done 2 cycles, timeout after TIMEOUT_CYCLES.
// Request held stable until req_ready; responses outside the wait window are dropped.
module challenge_initiator
   import challenge_initiator_pkg::*;
#(
   parameter int MSG_LEN        = 832,
   parameter int HDR_W          = 32,
   parameter int MAX_SLOT       = 7,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [7:0]               slot_in,
   input  logic [255:0]             nonce_in,
   output logic                     req_valid,
   input  logic                     req_ready,
   output logic [HDR_W-1:0]         req_header,
   output logic [255:0]             req_payload,
   input  logic                     resp_valid,
   input  logic [HDR_W-1:0]         resp_header,
   input  logic [MSG_LEN-HDR_W-1:0] resp_payload,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [2:0]               err_code,
   output logic [7:0]               err_info,
   output logic [MSG_LEN-HDR_W-1:0] auth_payload
);

   localparam int PL_W  = MSG_LEN - HDR_W;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [7:0]         slot_q;
   logic [255:0]       nonce_q;
   logic [HDR_W-1:8]   hdr_q;
   logic [PL_W-1:0]    pl_q;
   logic               start_ok, start_bad, hs, resp_take, tmo, cnt_en;
   logic               chk_pass;
   logic [2:0]         chk_err;
   logic [7:0]         chk_info;
   logic               unused_param2;

   // Param2 of the reply is deliberately never inspected.
   assign unused_param2 = ^resp_header[7:0];

   assign req_header  = req_valid ? HDR_W'(challenge_header(slot_q)) : '0;
   assign req_payload = nonce_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      start_bad = 1'b0;
      hs        = 1'b0;
      resp_take = 1'b0;
      tmo       = 1'b0;
      cnt_en    = 1'b0;
      req_valid = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (slot_in > 8'(MAX_SLOT)) begin
                  start_bad = 1'b1;
                  state_nxt = ST_DONE;
               end else begin
                  start_ok  = 1'b1;
                  state_nxt = ST_SEND;
               end
            end
         end
         ST_SEND: begin
            req_valid = 1'b1;
            if (req_ready) begin
               hs        = 1'b1;
               state_nxt = ST_WAIT_RESP;
            end
         end
         ST_WAIT_RESP: begin
            // A response on the terminal-count cycle still beats the timeout.
            if (resp_valid) begin
               resp_take = 1'b1;
               state_nxt = ST_CHECK;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               tmo       = 1'b1;
               state_nxt = ST_DONE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_CHECK: state_nxt = ST_DONE;
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt          <= '0;
         slot_q       <= '0;
         nonce_q      <= '0;
         hdr_q        <= '0;
         pl_q         <= '0;
         pass         <= 1'b0;
         err_code     <= ERR_NONE;
         err_info     <= '0;
         auth_payload <= '0;
      end else begin
         if (hs)          cnt <= '0;
         else if (cnt_en) cnt <= cnt + 1'b1;
         if (start_ok) begin
            slot_q  <= slot_in;
            nonce_q <= nonce_in;
         end
         if (start_ok || start_bad) begin
            pass         <= 1'b0;
            err_code     <= start_bad ? ERR_BAD_SLOT : ERR_NONE;
            err_info     <= '0;
            auth_payload <= '0;
         end
         if (resp_take) begin
            hdr_q <= resp_header[HDR_W-1:8];
            pl_q  <= resp_payload;
         end
         if (tmo) err_code <= ERR_TIMEOUT;
         if (state == ST_CHECK) begin
            pass         <= chk_pass;
            err_code     <= chk_err;
            err_info     <= chk_info;
            auth_payload <= chk_pass ? pl_q : '0;
         end
      end
   end

   challenge_initiator_resp_checker u_checker (
      .version  (hdr_q[HDR_W-1 -: 8]),
      .msg_type (hdr_q[HDR_W-9 -: 8]),
      .param1   (hdr_q[HDR_W-17 -: 8]),
      .exp_slot (slot_q),
      .pass     (chk_pass),
      .err_code (chk_err),
      .err_info (chk_info)
   );

endmodule
